// File: rtl/dpram_fifo_ctrl.sv
// ============================================================================
//  Module   : dpram_fifo_ctrl
//  Brief    : FWFT valid/ready FIFO controller driving an external simple
//             dual-port single-clock RAM; the RAM read register is the output
//             stage. Optional synchronous flush port: DPRAM_FIFO_CTRL_FLUSH_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dpram_fifo_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef DPRAM_FIFO_CTRL_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [ADDR_WIDTH:0]   count
);

    localparam logic [ADDR_WIDTH:0] c_depth = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] c_one   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0] r_wptr;
    logic [ADDR_WIDTH:0] r_rptr;
    logic                r_m_valid;

    logic [ADDR_WIDTH:0] w_occ;
    logic                w_clear;
    logic                w_push;
    logic                w_rd;

`ifdef DPRAM_FIFO_CTRL_FLUSH_EN
    assign w_clear = rst | flush;
`else
    assign w_clear = rst;
`endif

    // Occupancy comes from registered pointers only, so a word written this
    // cycle cannot be read until the next one and no RAM bypass is needed.
    assign w_occ   = r_wptr - r_rptr;
    assign s_ready = (w_occ != c_depth);
    assign w_push  = s_valid && s_ready && !w_clear;
    assign w_rd    = (w_occ != '0) && (!r_m_valid || m_ready) && !w_clear;

    assign ram_wr_en = w_push;
    assign ram_waddr = r_wptr[ADDR_WIDTH-1:0];
    assign ram_din   = s_data;
    assign ram_rd_en = w_rd;
    assign ram_raddr = r_rptr[ADDR_WIDTH-1:0];

    assign m_valid = r_m_valid;
    assign m_data  = ram_dout;
    assign count   = w_occ + {{ADDR_WIDTH{1'b0}}, r_m_valid};

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_m_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_one;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + c_one;
            end
            // A read refills the output register; otherwise a taken word empties it.
            if (w_rd) begin
                r_m_valid <= 1'b1;
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/dpram_fifo_ctrl.md
DPRAM_FIFO_CTRL -- requirements
Module: dpram_fifo_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4: RAM address width; RAM depth DEPTH = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: word width.
REQ-003 SHALL use one clock and synchronous active-high reset: clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports s_valid input 1, s_ready output 1, s_data input DATA_WIDTH: write-side valid/ready handshake.
REQ-006 SHALL have ports m_valid output 1, m_ready input 1, m_data output DATA_WIDTH: read-side valid/ready handshake, first-word-fall-through.
REQ-007 SHALL have ports ram_wr_en output 1, ram_waddr output ADDR_WIDTH, ram_din output DATA_WIDTH: drive the write port of an external simple dual-port single-clock RAM.
REQ-008 SHALL have ports ram_rd_en output 1, ram_raddr output ADDR_WIDTH, ram_dout input DATA_WIDTH: drive the registered read port of that RAM (1-cycle latency, ram_dout holds while ram_rd_en low).
REQ-009 SHALL have port count output ADDR_WIDTH+1: words held (RAM occupancy plus output stage).

Function
REQ-010 SHALL keep wptr and rptr as ADDR_WIDTH+1-bit registers; RAM occupancy occ = wptr - rptr (modulo 2**(ADDR_WIDTH+1)); addresses are the low ADDR_WIDTH bits; pointers wrap naturally.
REQ-011 SHALL drive s_ready = (occ != DEPTH) combinationally from registered state; push = s_valid && s_ready.
REQ-012 SHALL on push assert ram_wr_en, ram_waddr = wptr[ADDR_WIDTH-1:0], ram_din = s_data in the same cycle, and increment wptr.
REQ-013 SHALL drive ram_rd_en = (occ != 0) && (!m_valid || m_ready); ram_raddr = rptr[ADDR_WIDTH-1:0]; increment rptr when ram_rd_en.
REQ-014 SHALL use the RAM read register as the output stage: m_data = ram_dout; m_valid set the cycle after ram_rd_en; cleared when m_valid && m_ready and ram_rd_en is low.
REQ-015 SHALL evaluate occ from registered pointers only, so a word is never read in the cycle it is written (no RAM bypass needed); push-to-m_valid latency is exactly 2 cycles on an empty block.
REQ-016 SHALL sustain one push and one pop per cycle concurrently, including when occ == DEPTH (push blocked) and occ == 0 (read not issued).
REQ-017 SHALL hold m_data stable while m_valid && !m_ready.
REQ-018 SHALL drive count = occ + m_valid; maximum DEPTH+1.
REQ-019 SHALL ignore s_data when s_valid is low and m_ready when m_valid is low.

Reset
REQ-020 SHALL on rst clear wptr, rptr, m_valid; count = 0, s_ready = 1 and m_valid = 0 the cycle after reset.
REQ-021 SHALL force ram_wr_en = 0 and ram_rd_en = 0 while rst is high; a push or pop coincident with rst is discarded.
REQ-022 SHALL treat rst mid-stream as a full discard: no stale word appears on m_valid after reset.

Configuration
REQ-023 SHALL, when macro DPRAM_FIFO_CTRL_FLUSH_EN is defined, add port flush input 1: synchronous flush clearing wptr, rptr, m_valid like rst, with ram_wr_en and ram_rd_en forced low in that cycle; a push coincident with flush is discarded.
REQ-024 SHALL, when DPRAM_FIFO_CTRL_FLUSH_EN is undefined, have no flush port and no flush logic.

Verification
REQ-025 SHALL verify (ADDR_WIDTH=2) single push 0xA5 into empty block at cycle N, m_ready=1 -> ram_rd_en at N+1, m_valid=1 and m_data=0xA5 at N+2, count 0 at N+3.
REQ-026 SHALL verify 5 pushes 0x1..0x5 with m_ready=0 -> s_ready=0 after the 5th (count=5), m_data=0x1 held; then m_ready=1 -> 0x1..0x5 in order, one per cycle.
REQ-027 SHALL verify continuous push and pop, 12 words (pointer wrap ×3) -> output sequence equals input, no gaps after 2-cycle fill latency.
REQ-028 SHALL verify full block with s_valid=1 and m_ready=1 simultaneously -> one pop frees slot, push accepted next cycle, count stays between 4 and 5, no loss or duplicate.
REQ-029 SHALL verify rst asserted with count=3 and s_valid=1 -> next cycle count=0, m_valid=0, s_ready=1, no RAM write in reset cycle.
REQ-030 SHALL verify (DPRAM_FIFO_CTRL_FLUSH_EN defined) flush with count=4 and concurrent push 0x77 -> count=0, m_valid=0, 0x77 never output.
